// File: rtl/priority_decoder_monitor.sv
// Receive-side checker for a 4-to-2 priority encoder: decodes the observed code,
// compares it against a golden encoding, and classifies stuck-at faults per window.
module priority_decoder_monitor #(
  parameter int WINDOW = 16,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       d_in,
  input  logic [1:0]       y_in,
  output logic [3:0]       dec_out,
  output logic             dec_valid,
  output logic             mismatch,
  output logic [CNT_W-1:0] err_count,
  output logic [1:0]       sa0,
  output logic [1:0]       sa1,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    REPORT = 2'd2
  } state_t;

  localparam int              SCW     = (WINDOW > 1) ? $clog2(WINDOW) : 1;
  localparam logic [SCW-1:0]  LAST    = SCW'(WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Highest set bit of d wins; an all-zero input encodes as 00.
  function automatic logic [1:0] golden(input logic [3:0] d);
    logic [1:0] g;
    if (d[3]) begin
      g = 2'b11;
    end else if (d[2]) begin
      g = 2'b10;
    end else if (d[1]) begin
      g = 2'b01;
    end else begin
      g = 2'b00;
    end
    return g;
  endfunction

  state_t           state_r, state_nxt_s;
  logic [SCW-1:0]   smp_cnt_r;
  logic [CNT_W-1:0] err_cnt_r;
  logic [1:0]       f0_r, f1_r, seen0_r, seen1_r;
  logic [3:0]       dec_out_r;
  logic             dec_valid_r, mismatch_r;

  logic             accept_s, last_s, launch_s, miss_s;
  logic [1:0]       golden_s;

  assign golden_s = golden(d_in);
  assign miss_s   = (y_in != golden_s);
  assign accept_s = in_valid && (state_r == RUN);
  assign last_s   = accept_s && (smp_cnt_r == LAST);
  assign launch_s = start && (state_r != RUN);

  // Next-state selection for the window sequencer.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = IDLE;
      end
      RUN: begin
        if (last_s) state_nxt_s = REPORT;
        else        state_nxt_s = RUN;
      end
      REPORT: begin
        if (start) state_nxt_s = RUN;
        else       state_nxt_s = REPORT;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt_s;
  end

  // Window statistics: sample count, saturating error count, sticky fault flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      smp_cnt_r <= '0;
      err_cnt_r <= '0;
      f0_r      <= 2'b00;
      f1_r      <= 2'b00;
      seen0_r   <= 2'b00;
      seen1_r   <= 2'b00;
    end else if (launch_s) begin
      smp_cnt_r <= '0;
      err_cnt_r <= '0;
      f0_r      <= 2'b00;
      f1_r      <= 2'b00;
      seen0_r   <= 2'b00;
      seen1_r   <= 2'b00;
    end else if (accept_s) begin
      smp_cnt_r <= last_s ? '0 : smp_cnt_r + SCW'(1);
      if (miss_s && (err_cnt_r != CNT_MAX)) err_cnt_r <= err_cnt_r + CNT_W'(1);
      f0_r      <= f0_r | (golden_s & ~y_in);
      f1_r      <= f1_r | (~golden_s & y_in);
      seen0_r   <= seen0_r | ~y_in;
      seen1_r   <= seen1_r | y_in;
    end
  end

  // One-cycle-latency decode result; dec_out keeps its last value between accepts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_out_r   <= 4'b0000;
      dec_valid_r <= 1'b0;
      mismatch_r  <= 1'b0;
    end else begin
      dec_valid_r <= accept_s;
      mismatch_r  <= accept_s && miss_s;
      if (accept_s) dec_out_r <= 4'b0001 << y_in;
    end
  end

  assign in_ready  = (state_r == RUN);
  assign busy      = (state_r == RUN);
  assign done      = (state_r == REPORT);
  assign dec_out   = dec_out_r;
  assign dec_valid = dec_valid_r;
  assign mismatch  = mismatch_r;
  assign err_count = err_cnt_r;
  // A bit is stuck only if it failed one way and never showed the other value.
  assign sa0       = done ? (f0_r & ~seen1_r) : 2'b00;
  assign sa1       = done ? (f1_r & ~seen0_r) : 2'b00;

endmodule

// File: doc/priority_decoder_monitor.md
Name: priority_decoder_monitor

Overview:
Receive-side companion to the 4-to-2 priority encoder under fault test. Accepts stimulus/response pairs: the encoder input D and the encoder output Y. Decodes Y back to a one-hot vector and compares Y against a golden priority encoding of D. Over a fixed window of samples it counts mismatches and classifies each Y bit as stuck-at-0 or stuck-at-1.

Parameters:
WINDOW, 16, number of accepted samples per test window (>=1)
CNT_W, 8, width of the mismatch counter (saturating)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  single-cycle pulse; begins a new window from IDLE or REPORT
in_valid  input  1  d_in/y_in pair valid
in_ready  output  1  monitor accepts a sample; 1 only in RUN
d_in  input  4  encoder stimulus D
y_in  input  2  encoder response Y under test
dec_out  output  4  one-hot decode of accepted y_in (1 << y_in)
dec_valid  output  1  dec_out/mismatch valid this cycle
mismatch  output  1  accepted y_in differed from golden code
err_count  output  CNT_W  mismatches in current/last window, saturating
sa0  output  2  per-bit stuck-at-0 verdict, valid while done=1
sa1  output  2  per-bit stuck-at-1 verdict, valid while done=1
busy  output  1  state is RUN
done  output  1  state is REPORT

Behaviour:
- Reset (async, any time): state IDLE; all outputs 0; sample counter, err_count and sticky flags cleared. Reset mid-window discards the window.
- Golden code g from d_in: 1??? -> 11, 01?? -> 10, 001? -> 01, 0001 -> 00, 0000 -> 00.
- FSM: IDLE --start--> RUN; RUN --WINDOW-th accept--> REPORT; REPORT --start--> RUN. start in RUN is ignored. in_valid outside RUN is ignored.
- Entering RUN: sample counter, err_count and all sticky flags are cleared on the same edge.
- Accept = in_valid && in_ready. Latency is 1 cycle: on the edge after an accept, dec_valid=1, dec_out=1<<y_in, mismatch=(y_in!=g). Otherwise dec_valid=0 and mismatch=0. dec_out holds its last value.
- err_count increments on each mismatching accept. It holds at 2^CNT_W-1 once saturated.
- Sticky flags per bit i, updated on each accept:
  - f0[i] set when g[i]=1 and y_in[i]=0.
  - f1[i] set when g[i]=0 and y_in[i]=1.
  - seen1[i] set when y_in[i]=1.
  - seen0[i] set when y_in[i]=0.
- Verdicts: sa0[i] = f0[i] && !seen1[i]; sa1[i] = f1[i] && !seen0[i]. They are driven only in REPORT and read 0 elsewhere.
- The final accept of a window updates the counters and flags and moves to REPORT on the same edge. Its dec_valid/mismatch therefore appear in the first REPORT cycle, together with done=1 and the final verdicts.
- REPORT holds err_count, sa0 and sa1 stable until start.
- Gaps in in_valid are allowed. The sample counter advances only on accepts.

Test Plan:
- Fault-free: start, then 16 accepts cycling D=1000,0100,0010,0001 with correct Y -> err_count=0, sa0=00, sa1=00, done=1, in_ready=0.
- Y[1] stuck-at-0: same D sequence, y_in={0,g[0]} -> mismatch on D=1000 and D=0100 samples; err_count=8, sa0=10, sa1=00.
- Y[0] stuck-at-1: same D sequence, y_in={g[1],1} -> mismatch on D=0100 and D=0001 samples; err_count=8, sa1=01, sa0=00.
- Latency and gating:
  - In IDLE, in_valid=1 gives in_ready=0 and no dec_valid.
  - In RUN, accept y_in=10 with d_in=0100 -> next cycle dec_out=0100, dec_valid=1, mismatch=0.
  - Accept y_in=00 with d_in=0010 -> mismatch=1.
- Saturation: CNT_W=3, WINDOW=16, every sample mismatched -> err_count stops at 7; done asserts after the 16th accept.
- Reset mid-RUN: assert rst after 5 accepts -> all outputs 0 immediately, state IDLE. Then start plus 16 correct accepts -> err_count=0, done=1.
